vec_mem_seq: RTL and testbench

Multi-cycle memory sequencer on the consuming side of the execute-stage control register. It decodes the registered memory control fields (`cl_mem_op`, `cl_mem_st`) and performs either one scalar access or LANES sequential element accesses over a single-port request/acknowledge memory interface. It holds `stall` high so the control register's enable (`en = ~stall`) freezes the instruction until the access completes. Load results are returned on `rd_esc` / `rd_vec` with a one-cycle `done` pulse.

---
 rtl/vec_mem_seq.sv | 134 +++++++++++++
 tb/tb_vec_mem_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_seq.sv
// Multi-cycle memory sequencer for scalar and vector accesses.
// Holds stall until a single-port req/ack transfer completes.
module vec_mem_seq #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              cl_mem_op,
  input  logic                    cl_mem_st,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [DATA_W-1:0]       wr_esc,
  input  logic [LANES*DATA_W-1:0] wr_vec,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       rd_esc,
  output logic [LANES*DATA_W-1:0] rd_vec,
  output logic                    done
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           idx_n;
  logic                    vec_q;
  logic                    st_q;
  logic [ADDR_W-1:0]       base_q;
  logic [LANES*DATA_W-1:0] wvec_q;
  logic                    req_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rd_esc_q;
  logic [LANES*DATA_W-1:0] rd_vec_q;
  logic                    done_q;

  logic is_sc;
  logic is_vec;
  logic last;

  assign is_sc  = (cl_mem_op == 2'b01);
  assign is_vec = (cl_mem_op == 2'b10);
  assign idx_n  = idx_q + IW'(1);
  assign last   = !vec_q || (idx_q == IW'(LANES - 1));

  // Stall must rise in the issue cycle so the control register freezes.
  assign stall = ((state_q == IDLE) && (is_sc || is_vec))
              || (state_q == REQ);

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_esc    = rd_esc_q;
  assign rd_vec    = rd_vec_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      vec_q    <= 1'b0;
      st_q     <= 1'b0;
      base_q   <= '0;
      wvec_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_esc_q <= '0;
      rd_vec_q <= '0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_sc || is_vec) begin
            state_q <= REQ;
            idx_q   <= '0;
            vec_q   <= is_vec;
            st_q    <= cl_mem_st;
            base_q  <= base_addr;
            wvec_q  <= wr_vec;
            req_q   <= 1'b1;
            we_q    <= cl_mem_st;
            addr_q  <= base_addr;
            wdata_q <= is_vec ? wr_vec[DATA_W-1:0] : wr_esc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!st_q) begin
              if (vec_q)
                rd_vec_q[int'(idx_q)*DATA_W +: DATA_W] <= mem_rdata;
              else
                rd_esc_q <= mem_rdata;
            end
            if (last) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_n;
              addr_q  <= base_q + ADDR_W'(idx_n);
              wdata_q <= wvec_q[int'(idx_n)*DATA_W +: DATA_W];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a cycle-accurate memory responder.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_vec_mem_seq;

  logic        clk;
  logic        reset;
  logic [1:0]  cl_mem_op;
  logic        cl_mem_st;
  logic [15:0] base_addr;
  logic [7:0]  wr_esc;
  logic [31:0] wr_vec;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  rd_esc;
  logic [31:0] rd_vec;
  logic        done;

  int errs;
  int checks;
  int cyc;
  int t0;

  vec_mem_seq #(
    .LANES (4),
    .DATA_W(8),
    .ADDR_W(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cl_mem_op(cl_mem_op),
    .cl_mem_st(cl_mem_st),
    .base_addr(base_addr),
    .wr_esc   (wr_esc),
    .wr_vec   (wr_vec),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .rd_esc   (rd_esc),
    .rd_vec   (rd_vec),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one element: hold request for `waits` cycles, then ack.
  task automatic serve(input string tag,
                       input logic [15:0] addr,
                       input logic we,
                       input logic chk_wd,
                       input logic [7:0] wd,
                       input logic [7:0] rdata,
                       input int waits);
    for (int w = 0; w <= waits; w++) begin
      check({tag, " req"}, 64'(mem_req), 64'(1));
      check({tag, " stall"}, 64'(stall), 64'(1));
      check({tag, " addr"}, 64'(mem_addr), 64'(addr));
      check({tag, " we"}, 64'(mem_we), 64'(we));
      if (chk_wd)
        check({tag, " wdata"}, 64'(mem_wdata), 64'(wd));
      mem_ack   = (w == waits);
      mem_rdata = (w == waits) ? rdata : 8'h00;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic st,
                       input logic [15:0] base);
    cl_mem_op = op;
    cl_mem_st = st;
    base_addr = base;
    #1;
    check("issue stall", 64'(stall), 64'(1));
    check("issue req", 64'(mem_req), 64'(0));
    t0 = cyc;
    tick();
    cl_mem_op = 2'b00;
  endtask

  task automatic check_done(input string tag);
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " stall"}, 64'(stall), 64'(0));
    check({tag, " req"}, 64'(mem_req), 64'(0));
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    reset     = 1'b0;
    cl_mem_op = 2'b00;
    cl_mem_st = 1'b0;
    base_addr = 16'h0;
    wr_esc    = 8'h0;
    wr_vec    = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h0;
    #3;
    check("rst stall", 64'(stall), 64'(0));
    check("rst req", 64'(mem_req), 64'(0));
    check("rst we", 64'(mem_we), 64'(0));
    check("rst addr", 64'(mem_addr), 64'(0));
    check("rst wdata", 64'(mem_wdata), 64'(0));
    check("rst rd_esc", 64'(rd_esc), 64'(0));
    check("rst rd_vec", 64'(rd_vec), 64'(0));
    check("rst done", 64'(done), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Scalar load, immediate ack
    wr_esc = 8'h99;
    issue(2'b01, 1'b0, 16'h0010);
    serve("sld", 16'h0010, 1'b0, 1'b0, 8'h00, 8'hA5, 0);
    check_done("sld");
    check("sld rd_esc", 64'(rd_esc), 64'hA5);
    check("sld latency", 64'(cyc - t0), 64'(2));
    tick();
    check("sld done pulse", 64'(done), 64'(0));

    // Vector load, two wait cycles on lane 1
    issue(2'b10, 1'b0, 16'h0100);
    serve("vld0", 16'h0100, 1'b0, 1'b0, 8'h00, 8'h11, 0);
    serve("vld1", 16'h0101, 1'b0, 1'b0, 8'h00, 8'h22, 2);
    serve("vld2", 16'h0102, 1'b0, 1'b0, 8'h00, 8'h33, 0);
    serve("vld3", 16'h0103, 1'b0, 1'b0, 8'h00, 8'h44, 0);
    check_done("vld");
    check("vld rd_vec", 64'(rd_vec), 64'h44332211);
    check("vld latency", 64'(cyc - t0), 64'(7));
    check("vld rd_esc kept", 64'(rd_esc), 64'hA5);
    tick();

    // Vector store
    wr_vec = 32'hDDCCBBAA;
    issue(2'b10, 1'b1, 16'h0200);
    wr_vec = 32'h0;
    serve("vst0", 16'h0200, 1'b1, 1'b1, 8'hAA, 8'hF0, 0);
    serve("vst1", 16'h0201, 1'b1, 1'b1, 8'hBB, 8'hF1, 1);
    serve("vst2", 16'h0202, 1'b1, 1'b1, 8'hCC, 8'hF2, 0);
    serve("vst3", 16'h0203, 1'b1, 1'b1, 8'hDD, 8'hF3, 0);
    check_done("vst");
    check("vst rd_vec kept", 64'(rd_vec), 64'h44332211);
    check("vst we low", 64'(mem_we), 64'(0));
    tick();

    // Address wrap
    issue(2'b10, 1'b0, 16'hFFFE);
    serve("wrp0", 16'hFFFE, 1'b0, 1'b0, 8'h00, 8'h01, 0);
    serve("wrp1", 16'hFFFF, 1'b0, 1'b0, 8'h00, 8'h02, 0);
    serve("wrp2", 16'h0000, 1'b0, 1'b0, 8'h00, 8'h03, 0);
    serve("wrp3", 16'h0001, 1'b0, 1'b0, 8'h00, 8'h04, 0);
    check_done("wrp");
    check("wrp rd_vec", 64'(rd_vec), 64'h04030201);
    tick();

    // No-op encodings
    for (int k = 0; k < 2; k++) begin
      cl_mem_op = (k == 0) ? 2'b00 : 2'b11;
      cl_mem_st = 1'b1;
      #1;
      check("nop stall", 64'(stall), 64'(0));
      tick();
      check("nop req", 64'(mem_req), 64'(0));
      check("nop done", 64'(done), 64'(0));
    end
    cl_mem_op = 2'b00;

    // Reset after lane 1 ack
    issue(2'b10, 1'b0, 16'h0300);
    serve("rmv0", 16'h0300, 1'b0, 1'b0, 8'h00, 8'h55, 0);
    serve("rmv1", 16'h0301, 1'b0, 1'b0, 8'h00, 8'h66, 0);
    check("rmv req pre", 64'(mem_req), 64'(1));
    reset = 1'b0;
    #1;
    check("rmv req", 64'(mem_req), 64'(0));
    check("rmv stall", 64'(stall), 64'(0));
    check("rmv done", 64'(done), 64'(0));
    check("rmv rd_vec", 64'(rd_vec), 64'(0));
    check("rmv rd_esc", 64'(rd_esc), 64'(0));
    tick();
    reset = 1'b1;
    tick();
    issue(2'b01, 1'b0, 16'h0020);
    serve("rsl", 16'h0020, 1'b0, 1'b0, 8'h00, 8'h5A, 0);
    check_done("rsl");
    check("rsl rd_esc", 64'(rd_esc), 64'h5A);
    tick();

    // Back-to-back: scalar store then held scalar load
    wr_esc = 8'h77;
    issue(2'b01, 1'b1, 16'h0400);
    cl_mem_op = 2'b01;
    cl_mem_st = 1'b0;
    base_addr = 16'h0401;
    wr_esc    = 8'h00;
    serve("b2s", 16'h0400, 1'b1, 1'b1, 8'h77, 8'hEE, 0);
    check_done("b2s");
    check("b2s rd_esc kept", 64'(rd_esc), 64'h5A);
    tick();
    check("b2l issue stall", 64'(stall), 64'(1));
    check("b2l issue req", 64'(mem_req), 64'(0));
    check("b2l issue done", 64'(done), 64'(0));
    tick();
    cl_mem_op = 2'b00;
    serve("b2l", 16'h0401, 1'b0, 1'b0, 8'h00, 8'h3C, 0);
    check_done("b2l");
    check("b2l rd_esc", 64'(rd_esc), 64'h3C);
    tick();
    check("end idle req", 64'(mem_req), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
